// File: rtl/system_0_led_driver_pkg.sv
// Shared constants and types for the system_0 LED driver: register map,
// per-LED mode encodings and datapath widths.
package system_0_led_driver_pkg;

    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_BLINK  = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned BLINK_W  = 24;
    localparam int unsigned NUM_LEDS = 4;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_PWM    = 2'b10,
        MODE_BOTH   = 2'b11
    } led_mode_e;

    // Bit 0 of the mode gates with the blink phase, bit 1 with the PWM output.
    function automatic logic led_gate(led_mode_e mode, logic blink_phase, logic pwm_on);
        return (mode[0] ? blink_phase : 1'b1) & (mode[1] ? pwm_on : 1'b1);
    endfunction

endpackage

// File: rtl/system_0_led_driver_if.sv
// Avalon-MM zero-wait-state slave bundle for the LED driver register file.
interface system_0_led_driver_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/system_0_led_timebase.sv
// Shared timebase: prescaler tick, PWM frame counter with shadowed duty,
// and the blink counter/phase.
module system_0_led_timebase
    import system_0_led_driver_pkg::*;
#(
    parameter int unsigned PWM_PRESCALE = 195
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DUTY_W-1:0]  duty_shadow_i,
    input  logic [BLINK_W-1:0] blink_div_i,
    input  logic               blink_clr_i,
    output logic               tick_o,
    output logic               frame_wrap_o,
    output logic               pwm_on_o,
    output logic               blink_phase_o,
    output logic [DUTY_W-1:0]  pwm_cnt_o,
    output logic [DUTY_W-1:0]  duty_active_o
);

    localparam logic [15:0] PRESCALE_TC = 16'(PWM_PRESCALE);

    logic [15:0]        presc_q, presc_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0]  duty_act_q, duty_act_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               tick;
    logic               frame_wrap;

    always_comb begin
        tick        = (presc_q == PRESCALE_TC);
        presc_d     = tick ? '0 : presc_q + 16'd1;
        pwm_cnt_d   = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        frame_wrap  = tick && (pwm_cnt_q == '1);
        // The shadow is sampled before any same-cycle bus write lands in it,
        // so a write on the wrap cycle is picked up one frame later.
        duty_act_d  = frame_wrap ? duty_shadow_i : duty_act_q;

        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (blink_clr_i) begin
            blink_cnt_d = '0;
        end else if (tick) begin
            if (blink_cnt_q == blink_div_i) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            duty_act_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_act_q  <= duty_act_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign tick_o        = tick;
    assign frame_wrap_o  = frame_wrap;
    assign pwm_on_o      = (pwm_cnt_q < duty_act_q);
    assign blink_phase_o = phase_q;
    assign pwm_cnt_o     = pwm_cnt_q;
    assign duty_active_o = duty_act_q;

endmodule

// File: rtl/system_0_led_driver.sv
// LED driver top: Avalon-MM register file, combinational read mux and the
// registered per-LED steady/blink/PWM output stage.
module system_0_led_driver
    import system_0_led_driver_pkg::*;
#(
    parameter int unsigned PWM_PRESCALE = 195
) (
    input  logic                 clk,
    input  logic                 reset_n,
    system_0_led_driver_if.slave bus,
    input  logic [3:0]           led_in,
    output logic [3:0]           led_out
);

    logic [7:0]         mode_q, mode_d;
    logic [BLINK_W-1:0] blink_div_q, blink_div_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [3:0]         led_out_q, led_out_d;

    logic               wr;
    logic               blink_clr;
    logic               tick;
    logic               frame_wrap;
    logic               pwm_on;
    logic               blink_phase;
    logic [DUTY_W-1:0]  pwm_cnt;
    logic [DUTY_W-1:0]  duty_active;
    logic               unused_ok;

    assign wr        = bus.chipselect && !bus.write_n;
    assign blink_clr = wr && (bus.address == ADDR_BLINK);
    assign unused_ok = ^{tick, frame_wrap, bus.writedata[31:BLINK_W]};

    system_0_led_timebase #(
        .PWM_PRESCALE (PWM_PRESCALE)
    ) u_timebase (
        .clk           (clk),
        .reset_n       (reset_n),
        .duty_shadow_i (duty_q),
        .blink_div_i   (blink_div_q),
        .blink_clr_i   (blink_clr),
        .tick_o        (tick),
        .frame_wrap_o  (frame_wrap),
        .pwm_on_o      (pwm_on),
        .blink_phase_o (blink_phase),
        .pwm_cnt_o     (pwm_cnt),
        .duty_active_o (duty_active)
    );

    always_comb begin
        mode_d      = mode_q;
        blink_div_d = blink_div_q;
        duty_d      = duty_q;
        if (wr) begin
            case (bus.address)
                ADDR_MODE:  mode_d      = bus.writedata[7:0];
                ADDR_BLINK: blink_div_d = bus.writedata[BLINK_W-1:0];
                ADDR_DUTY:  duty_d      = bus.writedata[DUTY_W-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_MODE:  bus.readdata[7:0]         = mode_q;
            ADDR_BLINK: bus.readdata[BLINK_W-1:0] = blink_div_q;
            ADDR_DUTY:  bus.readdata[DUTY_W-1:0]  = duty_q;
            default: begin
                bus.readdata[0]    = blink_phase;
                bus.readdata[1]    = (duty_q != duty_active);
                bus.readdata[15:8] = pwm_cnt;
            end
        endcase
    end

    always_comb begin
        led_out_d = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            led_out_d[i] = led_in[i] & led_gate(led_mode_e'(mode_q[2*i +: 2]), blink_phase, pwm_on);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= '0;
            blink_div_q <= '0;
            duty_q      <= '0;
            led_out_q   <= '0;
        end else begin
            mode_q      <= mode_d;
            blink_div_q <= blink_div_d;
            duty_q      <= duty_d;
            led_out_q   <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: doc/system_0_led_driver.md
# system_0_led_driver

Downstream stage of the 4-bit LED PIO: consumes the PIO's `out_port` bits and drives the physical LED pins with per-LED steady, blink, PWM-dim, or blink+dim behaviour. Configured through its own Avalon-MM zero-wait-state slave in the same `system_0` Qsys system. All logic runs on one clock; `led_in` is same-domain and needs no synchronizer.

## Interface
- `PWM_PRESCALE`, 195: a timebase `tick` is issued once every `PWM_PRESCALE+1` clk cycles; legal range 0..65535.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, combinational, zero wait states.
- `led_in`  in  4  LED enables from the PIO `out_port`.
- `led_out`  out  4  registered LED pin drive.

## Operation
- Write = `chipselect && !write_n`. Registers:
  - addr 0 MODE[7:0] rw: 2 bits per LED i at [2i+1:2i]. 00 steady, 01 blink, 10 PWM, 11 blink+PWM.
  - addr 1 BLINK_DIV[23:0] rw: the blink phase toggles after every BLINK_DIV+1 ticks. A write clears the blink counter; the phase is unchanged.
  - addr 2 DUTY[7:0] rw: shadow register. Reads return the shadow value. The active duty loads from the shadow only at PWM frame wrap.
  - addr 3 STATUS ro: bit0 blink_phase, bit1 duty_pending (shadow ≠ active), bits[15:8] pwm_cnt. Writes are ignored.
- Unused readdata bits read 0. readdata is valid whenever `address` is stable (chipselect not required, matching the PIO).
- Timebase:
  - 16-bit prescaler counts 0..PWM_PRESCALE; `tick` is asserted for one cycle at terminal count, then the prescaler wraps to 0.
  - 8-bit pwm_cnt increments on tick and wraps 255→0 (frame wrap). On the wrap tick, duty_active ← DUTY shadow.
  - pwm_on = pwm_cnt < duty_active. Duty 0 is always off; duty 255 is on for 255 of 256 ticks.
- Blink: a 24-bit counter increments on tick. When it equals BLINK_DIV, it clears and blink_phase toggles.
- Drive: led_out[i] ← led_in[i] & (MODE[2i] ? blink_phase : 1) & (MODE[2i+1] ? pwm_on : 1).
- Simultaneous events:
  - BLINK_DIV write coinciding with a blink tick: the write wins (counter cleared, no toggle).
  - DUTY write on the frame-wrap cycle: the active duty takes the old shadow value; the new value applies at the next wrap.

## Timing
- Reset values: all registers 0, prescaler 0, pwm_cnt 0, duty_active 0, blink_phase 0, led_out 0, readdata 0 (address 0 reads MODE = 0).
- Reset is asynchronous. Asserting it mid-frame zeroes everything immediately. After release, the first tick occurs PWM_PRESCALE+1 cycles later.
- Register write is visible on readdata the cycle after the write edge.
- led_out latency: 1 clk from a change on led_in, MODE, blink_phase, or pwm_on.
- A MODE change applies on the next clk. A DUTY change applies at the next frame wrap (up to 256×(PWM_PRESCALE+1) cycles).
- Blink half-period = (BLINK_DIV+1)×(PWM_PRESCALE+1) clk.

## Structure
- Package `system_0_led_driver_pkg`:
  - address constants `ADDR_MODE=0`, `ADDR_BLINK=1`, `ADDR_DUTY=2`, `ADDR_STATUS=3`;
  - mode encodings `MODE_STEADY`, `MODE_BLINK`, `MODE_PWM`, `MODE_BOTH`;
  - widths `DUTY_W=8`, `BLINK_W=24`.
- Sub-module `system_0_led_timebase`: prescaler, pwm_cnt, duty shadow transfer, and blink counter/phase. Outputs tick, pwm_on, frame_wrap, blink_phase, pwm_cnt.
- Top level: register file, read mux, output drive.

## Test plan
- Reset: hold reset_n low mid-run, then release → led_out=0, readdata=0 at addresses 0–3. First tick occurs PWM_PRESCALE+1 cycles after release.
- Steady pass-through: MODE=0, drive led_in=4'b1010 → led_out=4'b1010 exactly 1 clk later; led_in=0 → led_out=0 next clk.
- PWM: PWM_PRESCALE=0, MODE=8'hAA, DUTY=64, led_in=4'hF, wait one frame wrap → each led_out high for exactly 64 of every 256 cycles, in phase.
- Duty shadow: write DUTY=200 mid-frame → STATUS bit1=1, duty unchanged until wrap. After wrap, duty_active=200 and bit1=0. A DUTY write on the wrap cycle is deferred one frame.
- Blink: PWM_PRESCALE=0, BLINK_DIV=3, MODE=8'h01, led_in=1 → led_out[0] toggles every 4 cycles. A BLINK_DIV write on a terminal tick suppresses that toggle.
- Bus: writes to STATUS are ignored. Read back MODE=8'h5C, BLINK_DIV=24'h123456, DUTY=8'h7F; upper bits read 0.
